// File: rtl/dct_transpose_ctrl_pkg.sv
// Shared constants and state encoding for the DCT transpose buffer controller.
// Consumed by the controller, its address generator and the column-stage reorder.
package dct_pkg;

  localparam int DCT_DW       = 33;
  localparam int DCT_BLK_LOG2 = 3;
  localparam int DCT_BLK_SIZE = 64;
  localparam int DCT_AW       = 2 * DCT_BLK_LOG2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } dct_state_e;

  typedef logic [DCT_AW-1:0] dct_addr_t;

endpackage

// File: rtl/dct_transpose_ctrl_if.sv
// Sample stream, transposed stream and buffer port bundle of the transpose controller.
// slave = controller side, master = environment (row DCT, column DCT, buffer).
interface dct_transpose_ctrl_if #(
  parameter int DW = 33,
  parameter int AW = 6
);

  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic          flush;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          buf_wea;
  logic [AW-1:0] buf_addra;
  logic [DW-1:0] buf_din;
  logic [DW-1:0] buf_dout;
  logic          ovf_err;

  modport slave (
    input  in_vld, in_data, flush, buf_dout,
    output in_rdy, out_vld, out_data, out_sop, out_eop,
    output buf_wea, buf_addra, buf_din, ovf_err
  );

  modport master (
    output in_vld, in_data, flush, buf_dout,
    input  in_rdy, out_vld, out_data, out_sop, out_eop,
    input  buf_wea, buf_addra, buf_din, ovf_err
  );

endinterface

// File: rtl/dct_transpose_ctrl_addr_gen.sv
// Block counter to buffer address map: mode 0 row-major, mode 1 column-major.
// Shared with the column-stage output reorder.
module dct_tp_addr_gen
  import dct_pkg::*;
#(
  parameter int N_LOG2 = DCT_BLK_LOG2
) (
  input  logic [2*N_LOG2-1:0] cnt_i,
  input  logic                mode_i,
  output logic [2*N_LOG2-1:0] addr_o
);

  assign addr_o = mode_i
    ? {cnt_i[N_LOG2-1:0], cnt_i[2*N_LOG2-1:N_LOG2]}
    : cnt_i;

endmodule

// File: rtl/dct_transpose_ctrl.sv
// In-place transpose controller for the single-port DCT block buffer.
// Optional input-overflow flag built when DCT_TP_OVF_CHK_EN is defined.
module dct_transpose_ctrl
  import dct_pkg::*;
#(
  parameter int DW     = DCT_DW,
  parameter int N_LOG2 = DCT_BLK_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  dct_transpose_ctrl_if.slave io
);

  localparam int AW = 2 * N_LOG2;
  localparam logic [AW-1:0] CNT_LAST = '1;

  dct_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          full_q, full_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] map_addr;
  logic          vld_q, sop_q, eop_q;

  logic accept, drain, access, last, rd_vld;

  dct_tp_addr_gen #(.N_LOG2(N_LOG2)) u_addr (
    .cnt_i  (cnt_q),
    .mode_i (mode_q),
    .addr_o (map_addr)
  );

  assign drain  = (state_q == DRAIN);
  assign accept = io.in_vld & ~drain;
  assign access = accept | drain;
  assign last   = (cnt_q == CNT_LAST);
  // a read is only meaningful while a previous block is held
  assign rd_vld = (accept & full_q) | drain;

  assign io.in_rdy   = ~drain;
  assign io.buf_wea  = accept;
  assign io.buf_din  = io.in_data;
  assign io.buf_addra = access ? map_addr : addr_q;

  assign io.out_vld  = vld_q;
  assign io.out_sop  = sop_q;
  assign io.out_eop  = eop_q;
  assign io.out_data = io.buf_dout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    full_d  = full_q;
    pend_d  = pend_q;
    if (access) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      EMPTY: begin
        if (accept && last) begin
          mode_d  = ~mode_q;
          full_d  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept && last) begin
          mode_d = ~mode_q;
          if (pend_q || io.flush) begin
            state_d = DRAIN;
            pend_d  = 1'b0;
          end
        end else if (io.flush) begin
          if (cnt_q == '0 && !accept) state_d = DRAIN;
          else                        pend_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (last) begin
          full_d  = 1'b0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      addr_q  <= io.buf_addra;
      vld_q   <= rd_vld;
      sop_q   <= rd_vld & (cnt_q == '0);
      eop_q   <= rd_vld & last;
    end
  end

`ifdef DCT_TP_OVF_CHK_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_q <= 1'b0;
    else if (io.in_vld && drain)   ovf_q <= 1'b1;
  end

  assign io.ovf_err = ovf_q;
`else
  assign io.ovf_err = 1'b0;
`endif

endmodule
